// File: rtl/csr_target_timeout_monitor.sv
// csr_target_timeout_monitor
//
// Default target for a pipelined CSR bus segment. A request that no other
// target claims is acknowledged after a programmable number of enabled
// cycles. Reads complete with zero data and a fixed error flag. Every
// timed-out request is captured (select/address/direction/data), counted in
// a saturating counter and flagged on a sticky interrupt. Software can then
// see which address decoded to nothing.
//
// Cycle numbering: cycle 0 is the first enabled cycle in which valid is
// sampled high in IDLE. With timeout T the acknowledge is high in cycle T+1.
// For reads, read_data_valid is high in cycle T+2. All outputs are registered.

module csr_target_timeout_monitor #(
    parameter int TIMEOUT_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int COUNT_WIDTH   = 8,
    parameter bit READ_ERROR    = 1'b1
) (
    input  logic                     clk,
    input  logic                     clk__enable,
    input  logic                     reset_n,

    input  logic [TIMEOUT_WIDTH-1:0] csr_timeout,

    input  logic                     csr_request__valid,
    input  logic                     csr_request__read_not_write,
    input  logic [15:0]              csr_request__select,
    input  logic [15:0]              csr_request__address,
    input  logic [DATA_WIDTH-1:0]    csr_request__data,

    input  logic                     status_clear,

    output logic                     csr_response__acknowledge,
    output logic                     csr_response__read_data_valid,
    output logic                     csr_response__read_data_error,
    output logic [DATA_WIDTH-1:0]    csr_response__read_data,

    output logic                     timeout_irq,
    output logic [COUNT_WIDTH-1:0]   timeout_count,
    output logic [15:0]              last_select,
    output logic [15:0]              last_address,
    output logic                     last_read_not_write,
    output logic [DATA_WIDTH-1:0]    last_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNTING,
        ST_ACK,
        ST_READ_DATA,
        ST_WAIT_DROP
    } state_t;

    state_t                   state;
    logic [TIMEOUT_WIDTH-1:0] counter;
    logic                     rnw_r;
    logic                     log_event;

    // A timeout fires on the last counting cycle if the master is still
    // holding the request. If valid has dropped, the request is treated as
    // aborted, even when the count has expired.
    assign log_event = (state == ST_COUNTING) &&
                       csr_request__valid &&
                       (counter == TIMEOUT_WIDTH'(1));

    // The default target never returns data.
    assign csr_response__read_data = '0;

    // Request sequencing: count down, acknowledge, optional read completion,
    // then wait for the master to release valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                         <= ST_IDLE;
            counter                       <= '0;
            rnw_r                         <= 1'b0;
            csr_response__acknowledge     <= 1'b0;
            csr_response__read_data_valid <= 1'b0;
            csr_response__read_data_error <= 1'b0;
        end else if (clk__enable) begin
            // NOTE: non-blocking assignments let the response strobes take a
            // default of 0 here and be raised below. Every register still
            // updates from values sampled at the same edge.
            csr_response__acknowledge     <= 1'b0;
            csr_response__read_data_valid <= 1'b0;
            csr_response__read_data_error <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // A zero timeout disables the block entirely.
                    if (csr_request__valid && (csr_timeout != '0)) begin
                        counter <= csr_timeout;
                        rnw_r   <= csr_request__read_not_write;
                        state   <= ST_COUNTING;
                    end
                end

                ST_COUNTING: begin
                    // The count was loaded on entry, so later changes to
                    // csr_timeout do not affect this request.
                    if (!csr_request__valid) begin
                        state <= ST_IDLE;
                    end else if (counter == TIMEOUT_WIDTH'(1)) begin
                        state                     <= ST_ACK;
                        csr_response__acknowledge <= 1'b1;
                    end else begin
                        counter <= counter - TIMEOUT_WIDTH'(1);
                    end
                end

                ST_ACK: begin
                    if (rnw_r) begin
                        state                         <= ST_READ_DATA;
                        csr_response__read_data_valid <= 1'b1;
                        csr_response__read_data_error <= READ_ERROR;
                    end else begin
                        state <= ST_WAIT_DROP;
                    end
                end

                ST_READ_DATA: begin
                    state <= ST_WAIT_DROP;
                end

                ST_WAIT_DROP: begin
                    // The master must release valid for at least one cycle
                    // before another request can be recognised.
                    if (!csr_request__valid) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture the identity of each timed-out request. Only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_select         <= '0;
            last_address        <= '0;
            last_read_not_write <= 1'b0;
            last_data           <= '0;
        end else if (clk__enable && log_event) begin
            last_select         <= csr_request__select;
            last_address        <= csr_request__address;
            last_read_not_write <= rnw_r;
            last_data           <= rnw_r ? '0 : csr_request__data;
        end
    end

    // Saturating timeout counter and sticky interrupt. A logging event takes
    // priority over a coincident status_clear, so that timeout is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_count <= '0;
            timeout_irq   <= 1'b0;
        end else if (clk__enable) begin
            if (log_event) begin
                timeout_irq <= 1'b1;
                if (status_clear) begin
                    timeout_count <= COUNT_WIDTH'(1);
                end else if (timeout_count != '1) begin
                    timeout_count <= timeout_count + COUNT_WIDTH'(1);
                end
            end else if (status_clear) begin
                timeout_count <= '0;
                timeout_irq   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csr_target_timeout_monitor.sv
// Self-checking bench for csr_target_timeout_monitor.
//
// The reference model works at the transaction level. For a request started
// in cycle 0 with timeout T, it expects an acknowledge in enabled cycle T+1.
// It also expects read completion in T+2, but only if valid is still held
// through cycle T. The counter is modelled as min(count+1, max) with a
// clear. Inputs are driven at the falling edge, and outputs are sampled
// there after each rising edge.

module tb_csr_target_timeout_monitor;

    localparam int TW   = 16;
    localparam int DW   = 32;
    localparam int CW   = 2;
    localparam bit RE   = 1'b1;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clk__enable;
    logic          reset_n;
    logic [TW-1:0] csr_timeout;
    logic          csr_request__valid;
    logic          csr_request__read_not_write;
    logic [15:0]   csr_request__select;
    logic [15:0]   csr_request__address;
    logic [DW-1:0] csr_request__data;
    logic          status_clear;
    logic          csr_response__acknowledge;
    logic          csr_response__read_data_valid;
    logic          csr_response__read_data_error;
    logic [DW-1:0] csr_response__read_data;
    logic          timeout_irq;
    logic [CW-1:0] timeout_count;
    logic [15:0]   last_select;
    logic [15:0]   last_address;
    logic          last_read_not_write;
    logic [DW-1:0] last_data;

    always #5 clk = ~clk;

    csr_target_timeout_monitor #(
        .TIMEOUT_WIDTH (TW),
        .DATA_WIDTH    (DW),
        .COUNT_WIDTH   (CW),
        .READ_ERROR    (RE)
    ) dut (
        .clk                           (clk),
        .clk__enable                   (clk__enable),
        .reset_n                       (reset_n),
        .csr_timeout                   (csr_timeout),
        .csr_request__valid            (csr_request__valid),
        .csr_request__read_not_write   (csr_request__read_not_write),
        .csr_request__select           (csr_request__select),
        .csr_request__address          (csr_request__address),
        .csr_request__data             (csr_request__data),
        .status_clear                  (status_clear),
        .csr_response__acknowledge     (csr_response__acknowledge),
        .csr_response__read_data_valid (csr_response__read_data_valid),
        .csr_response__read_data_error (csr_response__read_data_error),
        .csr_response__read_data       (csr_response__read_data),
        .timeout_irq                   (timeout_irq),
        .timeout_count                 (timeout_count),
        .last_select                   (last_select),
        .last_address                  (last_address),
        .last_read_not_write           (last_read_not_write),
        .last_data                     (last_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_count;
    bit          m_irq;
    logic [15:0] m_sel;
    logic [15:0] m_addr;
    bit          m_rnw;
    logic [31:0] m_data;

    // Stimulus knobs
    bit en_rand;
    int clr_rate;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_irq   = 1'b0;
        m_sel   = '0;
        m_addr  = '0;
        m_rnw   = 1'b0;
        m_data  = '0;
    endtask

    task automatic check_status();
        check("timeout_count", 64'(timeout_count), 64'(m_count));
        check("timeout_irq", 64'(timeout_irq), 64'(m_irq));
        check("last_select", 64'(last_select), 64'(m_sel));
        check("last_address", 64'(last_address), 64'(m_addr));
        check("last_read_not_write", 64'(last_read_not_write), 64'(m_rnw));
        check("last_data", 64'(last_data), 64'(m_data));
    endtask

    // One request from the master's point of view.
    //   t        : timeout programmed at cycle 0 (0 = block disabled)
    //   abort_at : if nonzero (1..t), valid drops in that cycle, before the timeout
    //   extra    : extra cycles valid is held after the acknowledge cycle
    //   hold0    : cycles valid is held when t == 0
    //   gap      : extra low cycles after the mandatory two low cycles
    //   clr_at   : cycle index where status_clear is forced high (-1 none)
    task automatic do_txn(input int t, input bit rnw, input logic [15:0] sel,
                          input logic [15:0] addr, input logic [31:0] data,
                          input int abort_at, input int extra, input int hold0,
                          input int gap, input int clr_at);
        bit ok;
        int drop;
        int last_cycle;
        int j;
        int guard;
        bit en;
        bit clr;
        ok    = (t != 0) && (abort_at == 0);
        drop  = (t == 0) ? hold0 : ((abort_at != 0) ? abort_at : t + 2 + extra);
        last_cycle = drop + 1 + gap;
        j     = 0;
        guard = 0;

        csr_timeout                 = TW'(t);
        csr_request__read_not_write = rnw;
        csr_request__select         = sel;
        csr_request__address        = addr;
        csr_request__data           = data;

        while (j <= last_cycle) begin
            en  = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            clr = (j == clr_at) || (clr_rate != 0 && $urandom_range(0, clr_rate - 1) == 0);
            // The programmed timeout may change while counting without effect.
            if (ok && j >= 1 && j <= t) csr_timeout = TW'($urandom_range(0, 65535));
            clk__enable        = en;
            csr_request__valid = (j < drop);
            status_clear       = clr;

            @(posedge clk);
            if (en) begin
                if (ok && j == t) begin
                    m_count = clr ? 1 : ((m_count == CMAX) ? CMAX : m_count + 1);
                    m_irq   = 1'b1;
                    m_sel   = sel;
                    m_addr  = addr;
                    m_rnw   = rnw;
                    m_data  = rnw ? 32'h0 : data;
                end else if (clr) begin
                    m_count = 0;
                    m_irq   = 1'b0;
                end
                j++;
            end

            @(negedge clk);
            check("acknowledge", 64'(csr_response__acknowledge), 64'(ok && j == t + 1));
            check("read_data_valid", 64'(csr_response__read_data_valid),
                  64'(ok && rnw && j == t + 2));
            check("read_data_error", 64'(csr_response__read_data_error),
                  64'(ok && rnw && j == t + 2 && RE));
            check("read_data", 64'(csr_response__read_data), 64'(0));
            check_status();

            guard++;
            if (guard > 5000) begin
                check("txn_cycle_budget", 64'(0), 64'(1));
                break;
            end
        end
    endtask

    initial begin
        clk__enable                 = 1'b1;
        reset_n                     = 1'b0;
        csr_timeout                 = '0;
        csr_request__valid          = 1'b0;
        csr_request__read_not_write = 1'b0;
        csr_request__select         = '0;
        csr_request__address        = '0;
        csr_request__data           = '0;
        status_clear                = 1'b0;
        en_rand                     = 1'b0;
        clr_rate                    = 0;
        model_reset();

        repeat (2) @(negedge clk);
        check("reset_acknowledge", 64'(csr_response__acknowledge), 64'(0));
        check("reset_read_data_valid", 64'(csr_response__read_data_valid), 64'(0));
        check("reset_read_data_error", 64'(csr_response__read_data_error), 64'(0));
        check_status();
        reset_n = 1'b1;
        @(negedge clk);

        // Write, T=4: ack in cycle 5 only, capture and logging
        do_txn(4, 1'b0, 16'h0005, 16'h0123, 32'hDEADBEEF, 0, 0, 0, 1, -1);
        check("wr_last_address", 64'(last_address), 64'(16'h0123));
        check("wr_last_data", 64'(last_data), 64'(32'hDEADBEEF));
        check("wr_count", 64'(timeout_count), 64'(1));
        check("wr_irq", 64'(timeout_irq), 64'(1));

        // Read, T=1: ack cycle 2, read completion cycle 3
        do_txn(1, 1'b1, 16'h0A0A, 16'h0456, 32'h12345678, 0, 0, 0, 1, -1);
        check("rd_last_rnw", 64'(last_read_not_write), 64'(1));
        check("rd_last_data", 64'(last_data), 64'(0));

        // Abort at cycle 6 of T=10, then a new request in cycle 8 (acks in cycle 19)
        do_txn(10, 1'b0, 16'h0001, 16'h0777, 32'h0000_1111, 6, 0, 0, 0, -1);
        check("abort_count", 64'(timeout_count), 64'(2));
        do_txn(10, 1'b0, 16'h0002, 16'h0888, 32'h0000_2222, 0, 0, 0, 1, -1);
        check("abort_new_last_address", 64'(last_address), 64'(16'h0888));

        // status_clear alone
        do_txn(0, 1'b0, 16'h0, 16'h0, 32'h0, 0, 0, 1, 0, 0);
        check("clear_count", 64'(timeout_count), 64'(0));
        check("clear_irq", 64'(timeout_irq), 64'(0));

        // Disabled: valid held 100 cycles with timeout 0
        do_txn(0, 1'b0, 16'h0003, 16'h0999, 32'h0, 0, 0, 100, 1, -1);
        check("disable_count", 64'(timeout_count), 64'(0));

        // Saturation: five timeouts on a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            do_txn(2, 1'b0, 16'h0010, 16'(16'h0100 + i), 32'(i), 0, 0, 0, 0, -1);
        end
        check("sat_count", 64'(timeout_count), 64'(CMAX));
        // Clear coincident with the sixth ack edge: the event wins
        do_txn(2, 1'b0, 16'h0011, 16'h0200, 32'hCAFE, 0, 0, 0, 0, 2);
        check("clr_coincident_count", 64'(timeout_count), 64'(1));
        check("clr_coincident_irq", 64'(timeout_irq), 64'(1));
        do_txn(0, 1'b0, 16'h0, 16'h0, 32'h0, 0, 0, 1, 0, 0);
        check("clr_alone_count", 64'(timeout_count), 64'(0));
        check("clr_alone_irq", 64'(timeout_irq), 64'(0));

        // Clock enable toggled during a T=3 read
        en_rand = 1'b1;
        do_txn(3, 1'b1, 16'h0020, 16'h0321, 32'h5555AAAA, 0, 1, 0, 1, -1);

        // Randomized traffic
        clr_rate = 12;
        for (int n = 0; n < 60; n++) begin
            int t;
            int ab;
            t  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            ab = (t != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, t)) : 0;
            en_rand = 1'($urandom_range(0, 1));
            do_txn(t, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), $urandom,
                   ab, int'($urandom_range(0, 3)), int'($urandom_range(1, 20)),
                   int'($urandom_range(0, 3)), -1);
        end

        // Reset while counting, then a fresh full count on the held request
        en_rand                     = 1'b0;
        clr_rate                    = 0;
        clk__enable                 = 1'b1;
        status_clear                = 1'b0;
        csr_timeout                 = TW'(8);
        csr_request__read_not_write = 1'b0;
        csr_request__select         = 16'h0042;
        csr_request__address        = 16'h0BAD;
        csr_request__data           = 32'h0BADF00D;
        csr_request__valid          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_acknowledge", 64'(csr_response__acknowledge), 64'(0));
        check("rst_read_data_valid", 64'(csr_response__read_data_valid), 64'(0));
        check("rst_read_data_error", 64'(csr_response__read_data_error), 64'(0));
        check_status();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_recount_ack", 64'(csr_response__acknowledge), 64'(k == 9));
        end
        check("rst_recount_count", 64'(timeout_count), 64'(1));
        check("rst_recount_last_address", 64'(last_address), 64'(16'h0BAD));
        csr_request__valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
